// File: rtl/wash_cycle_ctrl.sv
// Washing-machine sequencer: IDLE->FILL->WASH->RINSE->SPIN->IDLE, with optional
// double wash and cancel-to-spin. It drives the downstream Timer and advances on its Time_Event.
module wash_cycle_ctrl #(
  parameter logic [2:0] ENC_FILL  = 3'd0,
  parameter logic [2:0] ENC_WASH  = 3'd1,
  parameter logic [2:0] ENC_RINSE = 3'd2,
  parameter logic [2:0] ENC_SPIN  = 3'd3,
  parameter logic [2:0] ENC_IDLE  = 3'd7
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Coin_In,
  input  logic       Double_Wash,
  input  logic       Timer_Pause,
  input  logic       Cancel,
  input  logic       Time_Event,
  output logic [2:0] Timer_Encoding,
  output logic       Pause_Enable_T,
  output logic       Timer_Clear,
  output logic [2:0] State_Code,
  output logic       Wash_Done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WASH  = 3'd2,
    RINSE = 3'd3,
    SPIN  = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic       dbl_q, dbl_d;
  logic       pass_q, pass_d;
  logic [2:0] enc_q, enc_d;
  logic       pause_q, pause_d;
  logic       clr_q, clr_d;
  logic       done_q, done_d;

  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    state_d = IDLE;
    dbl_d   = dbl_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE: begin
        if (Coin_In) begin
          state_d = FILL;
          dbl_d   = Double_Wash;
          pass_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      FILL:  state_d = Cancel ? SPIN : (Time_Event ? WASH : FILL);
      WASH:  state_d = Cancel ? SPIN : (Time_Event ? RINSE : WASH);
      RINSE: begin
        if (Cancel) begin
          state_d = SPIN;
        end else if (Time_Event) begin
          if (dbl_q && !pass_q) begin
            state_d = WASH;
            pass_d  = 1'b1;
          end else begin
            state_d = SPIN;
          end
        end else begin
          state_d = RINSE;
        end
      end
      // The registered pause, not the raw request, gates the event in SPIN.
      SPIN:    state_d = (Time_Event && !pause_q) ? IDLE : SPIN;
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      FILL:    enc_d = ENC_FILL;
      WASH:    enc_d = ENC_WASH;
      RINSE:   enc_d = ENC_RINSE;
      SPIN:    enc_d = ENC_SPIN;
      default: enc_d = ENC_IDLE;
    endcase

    clr_d   = (state_d != state_q) && (state_d != IDLE);
    done_d  = (state_q == SPIN) && (state_d == IDLE);
    pause_d = (state_d == SPIN) && Timer_Pause;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      dbl_q   <= 1'b0;
      pass_q  <= 1'b0;
      enc_q   <= ENC_IDLE;
      pause_q <= 1'b0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dbl_q   <= dbl_d;
      pass_q  <= pass_d;
      enc_q   <= enc_d;
      pause_q <= pause_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
    end
  end

  assign State_Code     = state_q;
  assign Timer_Encoding = enc_q;
  assign Pause_Enable_T = pause_q;
  assign Timer_Clear    = clr_q;
  assign Wash_Done      = done_q;

endmodule
